fifo_ovf_reporter: RTL and testbench

- Watches the write side of a stream FIFO, in the same position as the FIFO overflow monitor, and sits directly downstream of that detection stage.
- Groups stall cycles (tvalid high, tready low) into overflow "episodes".
- For each new episode, emits one timestamped 128-bit report beat on an AXI-Stream output, for the capture/DMA path.
- Also keeps a sticky overflow flag and running counters for status registers.

---
 rtl/fifo_ovf_reporter.sv | 185 ++++++++++++++++++
 tb/tb_fifo_ovf_reporter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_ovf_reporter.sv
// fifo_ovf_reporter: groups write-side stall cycles of a stream FIFO into
// overflow episodes and emits one timestamped 128-bit report beat per new
// episode. Also keeps a sticky overflow flag and saturating/wrapping counters
// for status registers.
module fifo_ovf_reporter #(
    parameter int DW  = 512,
    parameter int GAP = 4
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          clear,
    input  logic          stream_tvalid,
    input  logic          stream_tready,
    input  logic [DW-1:0] stream_tdata,
    output logic          overflow,
    output logic [31:0]   stall_count,
    output logic [127:0]  report_tdata,
    output logic          report_tvalid,
    input  logic          report_tready
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    localparam logic [8:0] GAP_LIM = 9'(GAP);

    state_t         r_state;
    state_t         w_state_nxt;
    logic [47:0]    r_ts;
    logic [31:0]    r_beats;
    logic [31:0]    r_stall_count;
    logic [15:0]    r_epnum;
    logic [15:0]    r_missed;
    logic           r_in_ep;
    logic [7:0]     r_gap;
    logic           r_overflow;
    logic [127:0]   r_rec;

    logic           w_stall;
    logic           w_accept;
    logic           w_start;
    logic           w_hs;
    logic           w_load;
    logic           w_miss;
    logic [15:0]    w_epnum_inc;
    logic [8:0]     w_gap_inc;
    logic [127:0]   w_record;
    logic           w_unused;

    // The monitored data payload carries no information for this block.
    assign w_unused = ^stream_tdata;

    assign w_stall     = stream_tvalid & ~stream_tready;
    assign w_accept    = stream_tvalid & stream_tready;
    // A stall during clear is discarded, so it can never open an episode.
    assign w_start     = w_stall & ~r_in_ep & ~clear;
    // Gated by the SEND state so an undriven ready while idle is harmless.
    assign w_hs        = (r_state == ST_SEND) & report_tready;
    assign w_epnum_inc = r_epnum + 16'd1;
    assign w_gap_inc   = {1'b0, r_gap} + 9'd1;
    assign w_record    = {r_ts, r_beats, w_epnum_inc, r_missed, 16'h0000};

    assign overflow      = r_overflow;
    assign stall_count   = r_stall_count;
    assign report_tdata  = r_rec;
    assign report_tvalid = (r_state == ST_SEND);

    // Report FSM state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Report FSM next state, record load and dropped-report decisions.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_miss      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_SEND;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (w_hs) begin
                    if (w_start) begin
                        w_load      = 1'b1;
                        w_state_nxt = ST_SEND;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else if (w_start) begin
                    w_miss      = 1'b1;
                end else begin
                    w_state_nxt = ST_SEND;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Report record holding register; stable while a beat is pending.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rec <= 128'd0;
        end else if (w_load) begin
            r_rec <= w_record;
        end
    end

    // Free-running timestamp; deliberately immune to clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ts <= 48'd0;
        end else begin
            r_ts <= r_ts + 48'd1;
        end
    end

    // Sticky flag and status counters, all zeroed by clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_overflow    <= 1'b0;
            r_beats       <= 32'd0;
            r_stall_count <= 32'd0;
            r_missed      <= 16'd0;
        end else if (clear) begin
            r_overflow    <= 1'b0;
            r_beats       <= 32'd0;
            r_stall_count <= 32'd0;
            r_missed      <= 16'd0;
        end else begin
            if (w_stall) begin
                r_overflow <= 1'b1;
            end
            if (w_accept) begin
                r_beats <= r_beats + 32'd1;
            end
            if (w_stall && (r_stall_count != 32'hFFFF_FFFF)) begin
                r_stall_count <= r_stall_count + 32'd1;
            end
            if (w_miss && (r_missed != 16'hFFFF)) begin
                r_missed <= r_missed + 16'd1;
            end
        end
    end

    // Episode tracker: opens on a stall, closes after GAP quiet cycles.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_in_ep <= 1'b0;
            r_gap   <= 8'd0;
            r_epnum <= 16'd0;
        end else if (clear) begin
            r_in_ep <= 1'b0;
            r_gap   <= 8'd0;
            r_epnum <= 16'd0;
        end else if (w_start) begin
            r_in_ep <= 1'b1;
            r_gap   <= 8'd0;
            r_epnum <= w_epnum_inc;
        end else if (r_in_ep) begin
            if (w_stall) begin
                r_gap <= 8'd0;
            end else if (w_gap_inc == GAP_LIM) begin
                r_in_ep <= 1'b0;
                r_gap   <= 8'd0;
            end else begin
                r_gap <= w_gap_inc[7:0];
            end
        end
    end

endmodule

// File: tb/tb_fifo_ovf_reporter.sv
// Directed bench for fifo_ovf_reporter: a cycle model pushes expected report
// records into a queue as stimulus creates episodes; every presented report
// beat is compared against the queue head, plus directed field checks.
module tb_fifo_ovf_reporter;

    localparam int DW  = 512;
    localparam int GAP = 4;

    logic           clk = 1'b0;
    logic           resetn;
    logic           clear;
    logic           stream_tvalid;
    logic           stream_tready;
    logic [DW-1:0]  stream_tdata;
    logic           overflow;
    logic [31:0]    stall_count;
    logic [127:0]   report_tdata;
    logic           report_tvalid;
    logic           report_tready;

    fifo_ovf_reporter #(.DW(DW), .GAP(GAP)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .clear         (clear),
        .stream_tvalid (stream_tvalid),
        .stream_tready (stream_tready),
        .stream_tdata  (stream_tdata),
        .overflow      (overflow),
        .stall_count   (stall_count),
        .report_tdata  (report_tdata),
        .report_tvalid (report_tvalid),
        .report_tready (report_tready)
    );

    always #5 clk = ~clk;

    int             n_chk;
    int             n_fail;
    int             n_pop;
    logic [127:0]   exp_q[$];
    logic [127:0]   last_rec;
    logic [127:0]   prev_rec;

    // bench model state
    logic [47:0]    m_ts;
    logic [31:0]    m_beats;
    logic [15:0]    m_ep;
    logic [15:0]    m_missed;
    logic           m_in_ep;
    int             m_gap;
    logic           m_busy;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check presented report, advance model, cross the edge.
    task automatic step();
        logic         stall;
        logic         accept;
        logic         start;
        logic         hs;
        logic [127:0] rec;
        chk("tvalid", {127'd0, report_tvalid}, {127'd0, m_busy});
        hs = m_busy && (report_tready === 1'b1);
        if (m_busy) begin
            if (exp_q.size() > 0) begin
                chk("tdata", report_tdata, exp_q[0]);
                if (hs) begin
                    prev_rec = last_rec;
                    last_rec = report_tdata;
                    void'(exp_q.pop_front());
                    n_pop++;
                end
            end else begin
                chk("queue_nonempty", 128'd0, 128'd1);
            end
        end
        stall  = stream_tvalid && !stream_tready;
        accept = stream_tvalid && stream_tready;
        start  = stall && !m_in_ep && !clear;
        if (start) begin
            rec = {m_ts, m_beats, m_ep + 16'd1, m_missed, 16'h0000};
            if (!m_busy || hs) begin
                exp_q.push_back(rec);
                m_busy = 1'b1;
            end else if (m_missed != 16'hFFFF) begin
                m_missed = m_missed + 16'd1;
            end
        end else if (hs) begin
            m_busy = 1'b0;
        end
        m_ts = m_ts + 48'd1;
        if (clear) begin
            m_beats  = 32'd0;
            m_ep     = 16'd0;
            m_missed = 16'd0;
            m_in_ep  = 1'b0;
            m_gap    = 0;
        end else begin
            if (accept) m_beats = m_beats + 32'd1;
            if (start) begin
                m_in_ep = 1'b1;
                m_gap   = 0;
                m_ep    = m_ep + 16'd1;
            end else if (m_in_ep) begin
                if (stall) begin
                    m_gap = 0;
                end else if (m_gap + 1 == GAP) begin
                    m_in_ep = 1'b0;
                    m_gap   = 0;
                end else begin
                    m_gap = m_gap + 1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of stream inputs then advance.
    task automatic drive(input logic v, input logic r, input logic c, input int n);
        for (int i = 0; i < n; i++) begin
            stream_tvalid = v;
            stream_tready = r;
            clear         = c;
            stream_tdata  = {16{$urandom()}};
            step();
        end
        stream_tvalid = 1'b0;
        stream_tready = 1'b0;
        clear         = 1'b0;
    endtask

    int n0;

    initial begin
        n_chk = 0; n_fail = 0; n_pop = 0;
        last_rec = 128'd0; prev_rec = 128'd0;
        m_ts = 48'd0; m_beats = 32'd0; m_ep = 16'd0; m_missed = 16'd0;
        m_in_ep = 1'b0; m_gap = 0; m_busy = 1'b0;
        resetn = 1'b0; clear = 1'b0; stream_tvalid = 1'b0; stream_tready = 1'b0;
        stream_tdata = '0; report_tready = 1'b1;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_overflow", {127'd0, overflow}, 128'd0);
        chk("rst_stall_count", {96'd0, stall_count}, 128'd0);
        chk("rst_tdata", report_tdata, 128'd0);
        chk("rst_tvalid", {127'd0, report_tvalid}, 128'd0);
        resetn = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 100);

        // single episode
        drive(1'b1, 1'b1, 1'b0, 10);
        chk("pre_overflow", {127'd0, overflow}, 128'd0);
        drive(1'b1, 1'b0, 1'b0, 1);
        chk("overflow_set", {127'd0, overflow}, 128'd1);
        drive(1'b1, 1'b0, 1'b0, 2);
        chk("single_stall_count", {96'd0, stall_count}, 128'd3);
        drive(1'b0, 1'b0, 1'b0, 5);
        chk("single_npop", n_pop, 1);
        chk("single_ts", {80'd0, last_rec[127:80]}, 128'd110);
        chk("single_beats", {96'd0, last_rec[79:48]}, 128'd10);
        chk("single_epnum", {112'd0, last_rec[47:32]}, 128'd1);
        chk("single_missed", {112'd0, last_rec[31:16]}, 128'd0);
        chk("single_low", {112'd0, last_rec[15:0]}, 128'd0);

        // gap boundary: 3 quiet cycles keep the episode open
        drive(1'b0, 1'b0, 1'b1, 1);
        n0 = n_pop;
        drive(1'b1, 1'b0, 1'b0, 1);
        drive(1'b0, 1'b0, 1'b0, 3);
        drive(1'b1, 1'b0, 1'b0, 1);
        drive(1'b0, 1'b0, 1'b0, 5);
        chk("gap3_npop", n_pop - n0, 1);
        chk("gap3_epnum", {112'd0, last_rec[47:32]}, 128'd1);
        // gap boundary: 4 quiet cycles close it
        drive(1'b0, 1'b0, 1'b1, 1);
        n0 = n_pop;
        drive(1'b1, 1'b0, 1'b0, 1);
        drive(1'b0, 1'b0, 1'b0, 4);
        drive(1'b1, 1'b0, 1'b0, 1);
        drive(1'b0, 1'b0, 1'b0, 5);
        chk("gap4_npop", n_pop - n0, 2);
        chk("gap4_ep_first", {112'd0, prev_rec[47:32]}, 128'd1);
        chk("gap4_ep_second", {112'd0, last_rec[47:32]}, 128'd2);

        // backpressure: first record held, two reports dropped
        drive(1'b0, 1'b0, 1'b1, 1);
        report_tready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, 1'b0, 1);
            drive(1'b0, 1'b0, 1'b0, 4);
        end
        chk("bp_tvalid", {127'd0, report_tvalid}, 128'd1);
        chk("bp_held_epnum", {112'd0, report_tdata[47:32]}, 128'd1);
        chk("bp_held_missed", {112'd0, report_tdata[31:16]}, 128'd0);
        report_tready = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1);
        drive(1'b1, 1'b0, 1'b0, 1);
        drive(1'b0, 1'b0, 1'b0, 5);
        chk("bp_next_epnum", {112'd0, last_rec[47:32]}, 128'd4);
        chk("bp_next_missed", {112'd0, last_rec[31:16]}, 128'd2);

        // handshake and start in the same cycle
        drive(1'b0, 1'b0, 1'b1, 1);
        report_tready = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1);
        drive(1'b0, 1'b0, 1'b0, 4);
        n0 = n_pop;
        report_tready = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1);
        chk("hs_start_tvalid", {127'd0, report_tvalid}, 128'd1);
        chk("hs_start_epnum", {112'd0, report_tdata[47:32]}, 128'd2);
        chk("hs_start_prev_ep", {112'd0, last_rec[47:32]}, 128'd1);
        drive(1'b0, 1'b0, 1'b0, 5);
        chk("hs_start_npop", n_pop - n0, 2);

        // clear with a stall in the same cycle
        n0 = n_pop;
        drive(1'b1, 1'b0, 1'b1, 1);
        chk("clr_stall_count", {96'd0, stall_count}, 128'd0);
        chk("clr_overflow", {127'd0, overflow}, 128'd0);
        chk("clr_tvalid", {127'd0, report_tvalid}, 128'd0);
        drive(1'b0, 1'b0, 1'b0, 5);
        chk("clr_npop", n_pop - n0, 0);

        // stall_count saturation
        force dut.r_stall_count = 32'hFFFF_FFFD;
        #1;
        release dut.r_stall_count;
        drive(1'b1, 1'b0, 1'b0, 2);
        chk("sat_reach", {96'd0, stall_count}, {96'd0, 32'hFFFF_FFFF});
        drive(1'b1, 1'b0, 1'b0, 2);
        chk("sat_hold", {96'd0, stall_count}, {96'd0, 32'hFFFF_FFFF});
        drive(1'b0, 1'b0, 1'b0, 5);

        // beats wrap
        force dut.r_beats = 32'hFFFF_FFFE;
        m_beats = 32'hFFFF_FFFE;
        #1;
        release dut.r_beats;
        drive(1'b1, 1'b1, 1'b0, 3);
        drive(1'b1, 1'b0, 1'b0, 1);
        drive(1'b0, 1'b0, 1'b0, 5);
        chk("beats_wrap", {96'd0, last_rec[79:48]}, 128'd1);
        chk("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
